// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit type, digit limits and saturation helper
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;

    // Clamp an arbitrary nibble into the legal decimal range 0..9.
    function automatic bcd_t bcd_sat(input bcd_t x);
        return (x > BCD_MAX) ? BCD_MAX : x;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - single decimal digit register with carry/borrow generation
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset, q -> 0
//   step       advance this digit by one in the direction given by up
//   up         1 = increment, 0 = decrement (only meaningful with step)
//   set        synchronous load of set_val (higher priority than step)
//   set_val    value to load; saturated to 9 here as well
//   q          current digit value, always 0..9
//   carry_out  step && up && q == 9  (combinational, feeds next digit)
//   borrow_out step && !up && q == 0 (combinational, feeds next digit)
module bcd_digit
    import bcd_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic step,
    input  logic up,
    input  logic set,
    input  bcd_t set_val,
    output bcd_t q,
    output logic carry_out,
    output logic borrow_out
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= BCD_MIN;
        end else if (set) begin
            q <= bcd_sat(set_val);
        end else if (step) begin
            if (up) begin
                // >= rather than == so an out-of-range value can never persist
                q <= (q >= BCD_MAX) ? BCD_MIN : q + 4'd1;
            end else begin
                q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
            end
        end
    end

    assign carry_out  = step &&  up && (q == BCD_MAX);
    assign borrow_out = step && !up && (q == BCD_MIN);

endmodule

// File: rtl/bcd_counter.sv
// rtl/bcd_counter.sv - multi-digit BCD up/down counter with prescaler and wrap pulse
//
// Parameters:
//   DIGITS    number of decimal digits (1..8)
//   PRESCALE  enabled clock cycles per count step (>= 1)
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset
//   en        count enable, gates prescaler and counting
//   up        direction, sampled on the tick cycle only
//   clear     synchronous clear to zero (beats load and tick)
//   load      synchronous parallel load, digits > 9 saturate to 9
//   load_val  load value, digit i in bits [4i+3:4i]
//   bcd       registered count, digit 0 least significant
//   wrap      one-cycle pulse coincident with the wrapped count
module bcd_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  wrap
);

    localparam int             PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]     presc;
    logic              tick;
    logic              set;
    logic [DIGITS:0]   step_chain;
    logic [DIGITS-1:0] carry;
    logic [DIGITS-1:0] borrow;

    assign tick = en && (presc == PRESC_LAST);
    assign set  = clear || load;

    // Prescaler restarts on any synchronous set so the first step after
    // clear/load lands a full PRESCALE enabled cycles later.
    always_ff @(posedge clk) begin
        if (reset || set) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else if (en) begin
            presc <= presc + 1'b1;
        end
    end

    // Carry/borrow ripple is purely combinational, so all digits update on
    // the same edge. The top-digit overflow is registered as the wrap pulse.
    assign step_chain[0] = tick;

    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_digit
            bcd_t set_val;
            bcd_t q;

            assign set_val = clear ? BCD_MIN : load_val[4*i +: 4];

            bcd_digit u_digit (
                .clk        (clk),
                .reset      (reset),
                .step       (step_chain[i]),
                .up         (up),
                .set        (set),
                .set_val    (set_val),
                .q          (q),
                .carry_out  (carry[i]),
                .borrow_out (borrow[i])
            );

            assign bcd[4*i +: 4]   = q;
            assign step_chain[i+1] = up ? carry[i] : borrow[i];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || set) begin
            wrap <= 1'b0;
        end else begin
            wrap <= step_chain[DIGITS];
        end
    end

endmodule

// File: tb/tb_bcd_counter.sv
// tb/tb_bcd_counter.sv - self-checking bench for bcd_counter (PRESCALE 1 and 4)
module tb_bcd_counter;

    logic       clk = 1'b0;
    logic       reset, en, up, clear, load;
    logic [7:0] load_val;
    logic [7:0] bcd1, bcd4;
    logic       wrap1, wrap4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_counter #(.DIGITS(2), .PRESCALE(1)) u_p1 (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val), .bcd(bcd1), .wrap(wrap1)
    );

    bcd_counter #(.DIGITS(2), .PRESCALE(4)) u_p4 (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val), .bcd(bcd4), .wrap(wrap4)
    );

    // Reference model: the count is a plain decimal integer 0..99.
    int m_val  [2];
    int m_pre  [2];
    bit m_wrap [2];
    int m_ps   [2] = '{1, 4};

    function automatic int to_bcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    function automatic int sat_load(input int lv);
        int hi, lo;
        hi = lv / 16;
        lo = lv % 16;
        if (hi > 9) hi = 9;
        if (lo > 9) lo = 9;
        return hi * 10 + lo;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (reset || clear) begin
                m_val[k] = 0; m_pre[k] = 0; m_wrap[k] = 0;
            end else if (load) begin
                m_val[k] = sat_load(int'(load_val)); m_pre[k] = 0; m_wrap[k] = 0;
            end else if (en && m_pre[k] == m_ps[k] - 1) begin
                m_pre[k] = 0;
                if (up) begin
                    m_wrap[k] = (m_val[k] == 99);
                    m_val[k]  = (m_val[k] + 1) % 100;
                end else begin
                    m_wrap[k] = (m_val[k] == 0);
                    m_val[k]  = (m_val[k] + 99) % 100;
                end
            end else begin
                if (en) m_pre[k] = m_pre[k] + 1;
                m_wrap[k] = 0;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " bcd p1"},  32'(bcd1),  32'(to_bcd(m_val[0])));
        chk({tag, " wrap p1"}, 32'(wrap1), 32'(m_wrap[0]));
        chk({tag, " bcd p4"},  32'(bcd4),  32'(to_bcd(m_val[1])));
        chk({tag, " wrap p4"}, 32'(wrap4), 32'(m_wrap[1]));
    endtask

    task automatic drive(input bit r, input bit c, input bit l, input bit e, input bit u,
                         input logic [7:0] lv);
        reset = r; clear = c; load = l; en = e; up = u; load_val = lv;
    endtask

    typedef struct {
        bit         rst, clr, ld, en, up;
        logic [7:0] lv;
        logic [7:0] eb;
        bit         ew;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input bit r, input bit c, input bit l, input bit e, input bit u,
                                input logic [7:0] lv, input logic [7:0] eb, input bit ew);
        vec_t v;
        v.rst = r; v.clr = c; v.ld = l; v.en = e; v.up = u; v.lv = lv; v.eb = eb; v.ew = ew;
        return v;
    endfunction

    initial begin
        int n;
        // Vectors for the PRESCALE=1 instance, applied back to back.
        vt.push_back(mk(1,0,0,0,1,8'h00, 8'h00,0)); // reset
        vt.push_back(mk(0,0,1,0,1,8'hF3, 8'h93,0)); // load saturates high digit
        vt.push_back(mk(0,0,0,1,1,8'h00, 8'h94,0)); // count up
        vt.push_back(mk(0,1,1,1,1,8'h55, 8'h00,0)); // clear beats load and tick
        vt.push_back(mk(0,0,1,1,1,8'h27, 8'h27,0)); // load during tick, no increment
        vt.push_back(mk(0,0,0,1,0,8'h00, 8'h26,0)); // count down
        vt.push_back(mk(0,0,1,0,0,8'h10, 8'h10,0));
        vt.push_back(mk(0,0,0,1,0,8'h00, 8'h09,0)); // borrow, no wrap
        vt.push_back(mk(0,0,1,0,0,8'h00, 8'h00,0));
        vt.push_back(mk(0,0,0,1,0,8'h00, 8'h99,1)); // down wrap
        vt.push_back(mk(0,0,0,1,0,8'h00, 8'h98,0));
        vt.push_back(mk(0,0,1,0,1,8'h99, 8'h99,0));
        vt.push_back(mk(0,0,0,1,1,8'h00, 8'h00,1)); // up wrap
        vt.push_back(mk(0,0,0,1,1,8'h00, 8'h01,0));
        vt.push_back(mk(0,0,1,0,1,8'hA5, 8'h95,0)); // low digit fine, high saturates
        vt.push_back(mk(0,1,0,1,1,8'h00, 8'h00,0)); // clear ignores en
        vt.push_back(mk(0,0,0,0,1,8'h00, 8'h00,0)); // en low holds

        drive(1,0,0,0,1,8'h00);
        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rst, vt[i].clr, vt[i].ld, vt[i].en, vt[i].up, vt[i].lv);
            cycle();
            chk($sformatf("vec%0d bcd", i),  32'(bcd1),  32'(vt[i].eb));
            chk($sformatf("vec%0d wrap", i), 32'(wrap1), 32'(vt[i].ew));
            chk($sformatf("vec%0d p4 bcd", i), 32'(bcd4), 32'(to_bcd(m_val[1])));
        end

        // Full up count 00..99..00 on the PRESCALE=1 instance.
        drive(1,0,0,0,1,8'h00);
        cycle();
        chk("upcount reset", 32'(bcd1), 32'h0);
        for (int k = 1; k <= 100; k++) begin
            drive(0,0,0,1,1,8'h00);
            cycle();
            chk($sformatf("upcount %0d bcd", k),  32'(bcd1),
                32'({4'((k % 100) / 10), 4'(k % 10)}));
            chk($sformatf("upcount %0d wrap", k), 32'(wrap1), 32'(k == 100));
        end

        // PRESCALE=4: an en gap of 3 cycles delays the step by exactly 3 cycles.
        drive(1,0,0,0,1,8'h00);
        cycle();
        for (int k = 0; k < 2; k++) begin drive(0,0,0,1,1,8'h00); cycle(); end
        for (int k = 0; k < 3; k++) begin drive(0,0,0,0,1,8'h00); cycle(); end
        drive(0,0,0,1,1,8'h00);
        cycle();
        chk("presc before step", 32'(bcd4), 32'h00);
        cycle();
        chk("presc first step", 32'(bcd4), 32'h01);
        n = 0;
        while (bcd4 != 8'h02 && n < 10) begin cycle(); n++; end
        chk("presc step period", 32'(n), 32'd4);

        // Reset while a tick is pending at 57.
        drive(0,0,1,0,1,8'h57);
        cycle();
        for (int k = 0; k < 3; k++) begin drive(0,0,0,1,1,8'h00); cycle(); end
        chk("pending bcd", 32'(bcd4), 32'h57);
        drive(1,0,0,1,1,8'h00);
        cycle();
        chk("reset mid bcd",  32'(bcd4),  32'h00);
        chk("reset mid wrap", 32'(wrap4), 32'h0);
        for (int k = 0; k < 3; k++) begin drive(0,0,0,1,1,8'h00); cycle(); end
        chk("after reset hold", 32'(bcd4), 32'h00);
        cycle();
        chk("after reset step", 32'(bcd4), 32'h01);
        chk_model("seq end");

        // Random stimulus against the decimal reference model.
        up = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            reset    = ($urandom % 400) == 0;
            clear    = ($urandom % 60) == 0;
            load     = ($urandom % 40) == 0;
            en       = ($urandom % 4) != 0;
            if (($urandom % 64) == 0) up = ~up;
            load_val = 8'($urandom);
            cycle();
            chk_model("rand");
            chk("rand digit range",
                32'((bcd1[3:0] <= 4'd9) && (bcd1[7:4] <= 4'd9) &&
                    (bcd4[3:0] <= 4'd9) && (bcd4[7:4] <= 4'd9)), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
